// File: rtl/data_mem_arbiter.sv
// Two-master arbiter for the banked data memory: round-robin ownership with a
// bounded burst, combinational grant/mux, and read-return routing by tag.
module data_mem_arbiter #(
  parameter int READ_LAT  = 1,
  parameter int MAX_BURST = 4,
  parameter int AW        = 32,
  parameter int DW        = 32
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic [31:0]   m0_byte_mode,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic [31:0]   m1_byte_mode,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  output logic          mem_wren_o,
  output logic [31:0]   mem_byte_mode_o,
  input  logic [DW-1:0] mem_rdata_i
);

  localparam int CW = $clog2(MAX_BURST) + 1;
  localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          rr, rr_nx;
  logic          exhausted;
  logic          gnt0, gnt1;
  logic          push_v, push_id;
  logic [READ_LAT-1:0] tag_v, tag_id;

  // Grants are masked while reset is asserted so nothing leaks to memory.
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    exhausted = (cnt == BURST_MAX);
    if (state == OWN0 && m0_req && !(exhausted && m1_req)) begin
      gnt0 = 1'b1;
    end else if (state == OWN1 && m1_req && !(exhausted && m0_req)) begin
      gnt1 = 1'b1;
    end else if (m0_req && !m1_req) begin
      gnt0 = 1'b1;
    end else if (m1_req && !m0_req) begin
      gnt1 = 1'b1;
    end else if (m0_req && m1_req) begin
      if (state == OWN0)      gnt1 = 1'b1;
      else if (state == OWN1) gnt0 = 1'b1;
      else if (rr)            gnt1 = 1'b1;
      else                    gnt0 = 1'b1;
    end
    if (!RST) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

  always_comb begin
    state_nx = IDLE;
    cnt_nx   = '0;
    rr_nx    = rr;
    if (gnt0) begin
      state_nx = OWN0;
      rr_nx    = 1'b1;
      if (state == OWN0) cnt_nx = exhausted ? cnt : cnt + CW'(1);
      else               cnt_nx = CW'(1);
    end else if (gnt1) begin
      state_nx = OWN1;
      rr_nx    = 1'b0;
      if (state == OWN1) cnt_nx = exhausted ? cnt : cnt + CW'(1);
      else               cnt_nx = CW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
      cnt   <= '0;
      rr    <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      rr    <= rr_nx;
    end
  end

  assign push_v  = (gnt0 && !m0_we) || (gnt1 && !m1_we);
  assign push_id = gnt1;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      tag_v  <= '0;
      tag_id <= '0;
    end else begin
      for (int unsigned i = 1; i < READ_LAT; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
      tag_v[0]  <= push_v;
      tag_id[0] <= push_id;
    end
  end

  always_comb begin
    mem_addr_o      = '0;
    mem_wdata_o     = '0;
    mem_wren_o      = 1'b0;
    mem_byte_mode_o = '0;
    if (gnt0) begin
      mem_addr_o      = m0_addr;
      mem_wdata_o     = m0_wdata;
      mem_wren_o      = m0_we;
      mem_byte_mode_o = m0_byte_mode;
    end else if (gnt1) begin
      mem_addr_o      = m1_addr;
      mem_wdata_o     = m1_wdata;
      mem_wren_o      = m1_we;
      mem_byte_mode_o = m1_byte_mode;
    end
  end

  assign m0_gnt    = gnt0;
  assign m1_gnt    = gnt1;
  assign m0_rvalid = tag_v[READ_LAT-1] && !tag_id[READ_LAT-1];
  assign m1_rvalid = tag_v[READ_LAT-1] &&  tag_id[READ_LAT-1];
  assign m0_rdata  = mem_rdata_i;
  assign m1_rdata  = mem_rdata_i;

endmodule
